semaforo_fsm: RTL

SEMAFORO_FSM -- requirements
Module: semaforo_fsm

---
 rtl/semaforo_pkg.sv | 30 +++
 rtl/contador.sv | 21 ++
 rtl/semaforo_fsm.sv | 83 ++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// Shared state codes and default dwell counts for the traffic-light controller and its bench.
package semaforo_pkg;

  typedef enum logic [1:0] {
    StGreen  = 2'd0,
    StYellow = 2'd1,
    StRed    = 2'd2,
    StWalk   = 2'd3
  } state_e;

  localparam logic [2:0] DefGreenTime  = 3'd5;
  localparam logic [2:0] DefYellowTime = 3'd2;
  localparam logic [2:0] DefRedTime    = 3'd4;
  localparam logic [2:0] DefWalkTime   = 3'd3;

  // Lamp pattern {red, yellow, green}; WALK keeps cars on red.
  function automatic logic [2:0] lamps_of(state_e s);
    logic [2:0] l;
    l = 3'b100;
    unique case (s)
      StGreen:  l = 3'b001;
      StYellow: l = 3'b010;
      StRed:    l = 3'b100;
      StWalk:   l = 3'b100;
      default:  l = 3'b100;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/contador.sv
// Saturating dwell timer: clears on reset, counts up each cycle, flags count >= max_number.
module contador (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] max_number,
  output logic       bigger_than_max
);

  logic [2:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 3'd0;
    end else if (count_q != 3'd7) begin
      count_q <= count_q + 3'd1;
    end
  end

  assign bigger_than_max = (count_q >= max_number);

endmodule

// File: rtl/semaforo_fsm.sv
// Traffic-light sequencer with pedestrian walk phase; drives an external dwell timer.
module semaforo_fsm
  import semaforo_pkg::*;
#(
  parameter logic [2:0] GREEN_TIME  = DefGreenTime,
  parameter logic [2:0] YELLOW_TIME = DefYellowTime,
  parameter logic [2:0] RED_TIME    = DefRedTime,
  parameter logic [2:0] WALK_TIME   = DefWalkTime
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       timer_done,
  output logic       timer_reset,
  output logic [2:0] timer_max,
  output logic       light_red,
  output logic       light_yellow,
  output logic       light_green,
  output logic       walk,
  output logic [1:0] state
);

  state_e state_q;
  state_e next_state;
  logic   ped_pending;
  logic   accept;

  function automatic logic [2:0] dwell_of(state_e s);
    logic [2:0] d;
    d = RED_TIME;
    unique case (s)
      StGreen:  d = GREEN_TIME;
      StYellow: d = YELLOW_TIME;
      StRed:    d = RED_TIME;
      StWalk:   d = WALK_TIME;
      default:  d = RED_TIME;
    endcase
    return d;
  endfunction

  // The timer still holds the previous state's count during the entry cycle.
  assign accept = timer_done & ~timer_reset;

  always_comb begin
    next_state = state_q;
    unique case (state_q)
      StGreen:  next_state = StYellow;
      StYellow: next_state = StRed;
      StRed:    next_state = ped_pending ? StWalk : StGreen;
      StWalk:   next_state = StGreen;
      default:  next_state = StRed;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                                 <= StRed;
      timer_reset                             <= 1'b1;
      timer_max                               <= RED_TIME;
      {light_red, light_yellow, light_green}  <= 3'b100;
      walk                                    <= 1'b0;
      ped_pending                             <= 1'b0;
    end else if (accept) begin
      state_q                                 <= next_state;
      timer_reset                             <= 1'b1;
      timer_max                               <= dwell_of(next_state);
      {light_red, light_yellow, light_green}  <= lamps_of(next_state);
      walk                                    <= (next_state == StWalk);
      // Serving the walk consumes the request, but a request on this edge re-arms it.
      if (state_q == StRed && next_state == StWalk) begin
        ped_pending <= ped_req;
      end else begin
        ped_pending <= ped_pending | ped_req;
      end
    end else begin
      timer_reset <= 1'b0;
      ped_pending <= ped_pending | ped_req;
    end
  end

  assign state = state_q;

endmodule
